if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined MIPS CPU. It owns the PC, drives the instruction-memory address, and loads the IF/ID pipeline register. It applies stall and redirect (branch/jump flush) requests from the ID stage and hazard unit. It exports cycle, stall and flush counters so the testbench reads them directly instead of inferring them.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
CNT_W, 32, width of the performance counters
NOP_INSTR, 32'h0000_0000, word loaded into IF/ID on flush or while idle

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  run enable; pipeline advances only while high
stall_i  in  1  hazard unit: hold PC and IF/ID this cycle
branch_taken_i  in  1  ID stage: branch resolved taken
branch_target_i  in  32  branch target address
jump_i  in  1  ID stage: jump in ID
jump_target_i  in  32  jump target address
imem_addr_o  out  32  instruction-memory address; equals pc_o, combinational
imem_instr_i  in  32  instruction word returned combinationally for imem_addr_o
pc_o  out  32  current PC
ifid_instr_o  out  32  IF/ID instruction
ifid_pc4_o  out  32  IF/ID PC+4
ifid_valid_o  out  1  IF/ID holds a real fetched instruction
cycle_cnt_o  out  CNT_W  RUN cycles elapsed
stall_cnt_o  out  CNT_W  stalled cycles
flush_cnt_o  out  CNT_W  redirect/flush cycles
misalign_o  out  1  sticky: a redirect target had addr[1:0] != 0

Behaviour:
- Reset (async, rst_n_i low), all outputs:
  - pc_o = RESET_PC; ifid_instr_o = NOP_INSTR; ifid_pc4_o = 0; ifid_valid_o = 0.
  - All counters = 0; misalign_o = 0; state = IDLE.
- Reset deassertion is sampled synchronously. Reset mid-operation discards everything in flight.
- States: IDLE and RUN.
  - IDLE -> RUN on a rising edge with start_i=1. This transition edge updates nothing else.
  - RUN -> IDLE on a rising edge with start_i=0. That edge holds all registers and counts nothing.
  - In IDLE: all registers hold, counters frozen, inputs other than start_i ignored.
- RUN, evaluated per rising edge in priority order:
  1. stall_i=1:
     - PC and IF/ID hold; stall_cnt +1.
     - Any simultaneous branch_taken_i/jump_i is ignored: the redirecting instruction is itself stalled and re-presents next cycle.
  2. Redirect (branch_taken_i | jump_i):
     - PC <= target with bits[1:0] forced to 0. jump_i wins if both are asserted.
     - IF/ID <= NOP_INSTR, ifid_pc4_o <= 0, valid <= 0.
     - flush_cnt +1.
     - misalign_o set if the raw target had nonzero low bits.
  3. Normal:
     - PC <= PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
     - ifid_instr_o <= imem_instr_i; ifid_pc4_o <= PC+4; valid <= 1.
- cycle_cnt +1 on every RUN edge, including stall and flush edges.
- Counters saturate at all-ones and never wrap.
- Latency: instruction at PC appears on ifid_instr_o one cycle after the edge that samples it. The redirect target is fetched on the cycle following the redirect edge.
- misalign_o clears only on reset.

Decomposition:
- Shared package cpu_pkg holds:
  - NOP_INSTR and RESET_PC constants;
  - the fetch-state enum {IDLE, RUN};
  - a 2-bit next-PC select encoding (SEQ, BRANCH, JUMP, HOLD), reused by the hazard unit.
- One sub-module, if_perf_counters: three saturating CNT_W counters with per-counter increment enables and a global freeze.

Test Plan:
- Reset then start_i=1, memory words at 0,4,8 = A,B,C:
  - after 4 edges pc_o=12, ifid_instr_o=C, ifid_pc4_o=12, cycle_cnt=3.
- stall_i high for 2 edges at pc_o=8:
  - pc_o stays 8, ifid_instr_o unchanged, stall_cnt=2;
  - on release, fetch resumes at 8.
- branch_taken_i with target 0x40 at pc_o=12:
  - next pc_o=0x40, ifid_instr_o=0, ifid_valid_o=0, flush_cnt=1;
  - following cycle ifid_instr_o = mem[0x40].
- stall_i and jump_i together (target 0x80):
  - PC holds, stall_cnt+1, flush_cnt unchanged;
  - next edge with stall_i=0 redirects to 0x80.
- jump target 0x83:
  - pc_o=0x80, misalign_o=1, stays 1 through further redirects until rst_n_i pulses low.
- start_i dropped for 3 edges mid-run, then rst_n_i asserted asynchronously between edges:
  - counters frozen during the drop;
  - on reset, pc_o=0 and all counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch constants, fetch-state and next-PC select
// encodings used by the fetch stage and the hazard unit.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10,
      PC_HOLD   = 2'b11
   } pc_sel_e;

   function automatic logic [31:0] align_word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_perf_counters.sv
// Three saturating performance counters (cycle, stall, flush) with
// per-counter increment enables and a global freeze.
module if_perf_counters
   import cpu_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             freeze_i,
   input  logic             cyc_inc_i,
   input  logic             stall_inc_i,
   input  logic             flush_inc_i,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cycle;
   logic [CNT_W-1:0] r_stall;
   logic [CNT_W-1:0] r_flush;

   // Each counter sticks at all-ones instead of wrapping.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cycle <= '0;
         r_stall <= '0;
         r_flush <= '0;
      end else if (!freeze_i) begin
         if (cyc_inc_i && (r_cycle != '1))
            r_cycle <= r_cycle + ONE;
         if (stall_inc_i && (r_stall != '1))
            r_stall <= r_stall + ONE;
         if (flush_inc_i && (r_flush != '1))
            r_flush <= r_flush + ONE;
      end
   end

   assign cycle_cnt_o = r_cycle;
   assign stall_cnt_o = r_stall;
   assign flush_cnt_o = r_flush;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register,
// stall/redirect handling and performance counters.
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int unsigned CNT_W     = 32,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             branch_taken_i,
   input  logic [31:0]      branch_target_i,
   input  logic             jump_i,
   input  logic [31:0]      jump_target_i,
   output logic [31:0]      imem_addr_o,
   input  logic [31:0]      imem_instr_i,
   output logic [31:0]      pc_o,
   output logic [31:0]      ifid_instr_o,
   output logic [31:0]      ifid_pc4_o,
   output logic             ifid_valid_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             misalign_o
);

   fetch_state_e r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_ifid_instr;
   logic [31:0]  r_ifid_pc4;
   logic         r_ifid_valid;
   logic         r_misalign;

   logic         w_active;
   logic         w_redirect;
   pc_sel_e      w_pc_sel;
   logic [31:0]  w_pc4;
   logic [31:0]  w_raw_target;

   // Only a RUN edge with start_i still high advances; the IDLE->RUN and
   // RUN->IDLE edges themselves update nothing but the state.
   assign w_active = (r_state == RUN) && start_i;

   always_comb begin
      w_pc_sel = PC_HOLD;
      if (w_active && !stall_i) begin
         if (jump_i)
            w_pc_sel = PC_JUMP;
         else if (branch_taken_i)
            w_pc_sel = PC_BRANCH;
         else
            w_pc_sel = PC_SEQ;
      end
   end

   assign w_pc4        = r_pc + 32'd4;
   assign w_raw_target = (w_pc_sel == PC_JUMP) ? jump_target_i : branch_target_i;
   assign w_redirect   = (w_pc_sel == PC_JUMP) || (w_pc_sel == PC_BRANCH);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_ifid_instr <= NOP_INSTR;
         r_ifid_pc4   <= '0;
         r_ifid_valid <= 1'b0;
         r_misalign   <= 1'b0;
      end else begin
         case (r_state)
            IDLE:    if (start_i)  r_state <= RUN;
            RUN:     if (!start_i) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
         case (w_pc_sel)
            PC_SEQ: begin
               r_pc         <= w_pc4;
               r_ifid_instr <= imem_instr_i;
               r_ifid_pc4   <= w_pc4;
               r_ifid_valid <= 1'b1;
            end
            PC_BRANCH, PC_JUMP: begin
               r_pc         <= align_word(w_raw_target);
               r_ifid_instr <= NOP_INSTR;
               r_ifid_pc4   <= '0;
               r_ifid_valid <= 1'b0;
               if (w_raw_target[1:0] != 2'b00)
                  r_misalign <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   if_perf_counters #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .freeze_i    (!w_active),
      .cyc_inc_i   (1'b1),
      .stall_inc_i (stall_i),
      .flush_inc_i (w_redirect),
      .cycle_cnt_o (cycle_cnt_o),
      .stall_cnt_o (stall_cnt_o),
      .flush_cnt_o (flush_cnt_o)
   );

   assign imem_addr_o  = r_pc;
   assign pc_o         = r_pc;
   assign ifid_instr_o = r_ifid_instr;
   assign ifid_pc4_o   = r_ifid_pc4;
   assign ifid_valid_o = r_ifid_valid;
   assign misalign_o   = r_misalign;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table through a scoreboard queue,
// plus hand sequences for saturation, start drop and asynchronous reset.
module tb_if_stage;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] cyc;
      logic [31:0] st;
      logic [31:0] fl;
      logic        mis;
   } exp_t;

   typedef struct {
      logic        start;
      logic        stall;
      logic        br;
      logic [31:0] br_t;
      logic        jmp;
      logic [31:0] jmp_t;
      exp_t        e;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stall;
   logic        br;
   logic [31:0] br_t;
   logic        jmp;
   logic [31:0] jmp_t;
   logic [31:0] imem_addr, imem_instr, pc, ifid_instr, ifid_pc4;
   logic        ifid_valid, misalign;
   logic [31:0] cyc_cnt, st_cnt, fl_cnt;

   logic [31:0] s_addr, s_instr, s_pc, s_ifid_instr, s_ifid_pc4;
   logic        s_valid, s_mis;
   logic [2:0]  s_cyc, s_st, s_fl;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        sb[$];
   vec_t        vq[$];

   // Memory model: each word encodes its own low address bits.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   assign imem_instr = mem_word(imem_addr);
   assign s_instr    = mem_word(s_addr);

   if_stage #(
      .RESET_PC  (32'h0000_0000),
      .CNT_W     (32),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .start_i         (start),
      .stall_i         (stall),
      .branch_taken_i  (br),
      .branch_target_i (br_t),
      .jump_i          (jmp),
      .jump_target_i   (jmp_t),
      .imem_addr_o     (imem_addr),
      .imem_instr_i    (imem_instr),
      .pc_o            (pc),
      .ifid_instr_o    (ifid_instr),
      .ifid_pc4_o      (ifid_pc4),
      .ifid_valid_o    (ifid_valid),
      .cycle_cnt_o     (cyc_cnt),
      .stall_cnt_o     (st_cnt),
      .flush_cnt_o     (fl_cnt),
      .misalign_o      (misalign)
   );

   // Narrow-counter instance to reach saturation in a short run.
   if_stage #(
      .RESET_PC  (32'h0000_0000),
      .CNT_W     (3),
      .NOP_INSTR (32'h0000_0000)
   ) dut_s (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .start_i         (start),
      .stall_i         (stall),
      .branch_taken_i  (br),
      .branch_target_i (br_t),
      .jump_i          (jmp),
      .jump_target_i   (jmp_t),
      .imem_addr_o     (s_addr),
      .imem_instr_i    (s_instr),
      .pc_o            (s_pc),
      .ifid_instr_o    (s_ifid_instr),
      .ifid_pc4_o      (s_ifid_pc4),
      .ifid_valid_o    (s_valid),
      .cycle_cnt_o     (s_cyc),
      .stall_cnt_o     (s_st),
      .flush_cnt_o     (s_fl),
      .misalign_o      (s_mis)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, " pc"},    pc,                 e.pc);
      chk({tag, " instr"}, ifid_instr,         e.instr);
      chk({tag, " pc4"},   ifid_pc4,           e.pc4);
      chk({tag, " valid"}, {31'd0, ifid_valid}, {31'd0, e.valid});
      chk({tag, " cyc"},   cyc_cnt,            e.cyc);
      chk({tag, " stall"}, st_cnt,             e.st);
      chk({tag, " flush"}, fl_cnt,             e.fl);
      chk({tag, " mis"},   {31'd0, misalign},  {31'd0, e.mis});
   endtask

   function automatic vec_t mk(input logic s, input logic sl, input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt, input logic [31:0] p,
                               input logic [31:0] ins, input logic [31:0] p4, input logic v,
                               input logic [31:0] c, input logic [31:0] stc, input logic [31:0] flc,
                               input logic m);
      vec_t r;
      r.start = s; r.stall = sl; r.br = b; r.br_t = bt; r.jmp = j; r.jmp_t = jt;
      r.e.pc = p; r.e.instr = ins; r.e.pc4 = p4; r.e.valid = v;
      r.e.cyc = c; r.e.st = stc; r.e.fl = flc; r.e.mis = m;
      return r;
   endfunction

   // Called at a falling edge: drive, push expectation, pop and compare after the rising edge.
   task automatic step(input vec_t v, input string tag);
      exp_t e;
      start = v.start; stall = v.stall; br = v.br; br_t = v.br_t; jmp = v.jmp; jmp_t = v.jmp_t;
      sb.push_back(v.e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_all(tag, e);
      @(negedge clk);
   endtask

   initial begin
      exp_t rz;
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; br = 1'b0; jmp = 1'b0;
      br_t = '0; jmp_t = '0;

      //        st sl br br_t          jmp jmp_t         pc            instr         pc4           v  cyc st fl mis
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h0,        32'h0,        32'h0,        0, 0,  0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h4,        32'hC0DE0000, 32'h4,        1, 1,  0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h8,        32'hC0DE0004, 32'h8,        1, 2,  0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'hC,        32'hC0DE0008, 32'hC,        1, 3,  0, 0, 0));
      vq.push_back(mk(1, 0, 1, 32'h40,       0, 0,            32'h40,       32'h0,        32'h0,        0, 4,  0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h44,       32'hC0DE0040, 32'h44,       1, 5,  0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h48,       32'hC0DE0044, 32'h48,       1, 6,  0, 1, 0));
      vq.push_back(mk(1, 1, 0, 0,            0, 0,            32'h48,       32'hC0DE0044, 32'h48,       1, 7,  1, 1, 0));
      vq.push_back(mk(1, 1, 0, 0,            0, 0,            32'h48,       32'hC0DE0044, 32'h48,       1, 8,  2, 1, 0));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h4C,       32'hC0DE0048, 32'h4C,       1, 9,  2, 1, 0));
      vq.push_back(mk(1, 1, 0, 0,            1, 32'h80,       32'h4C,       32'hC0DE0048, 32'h4C,       1, 10, 3, 1, 0));
      vq.push_back(mk(1, 0, 0, 0,            1, 32'h80,       32'h80,       32'h0,        32'h0,        0, 11, 3, 2, 0));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h84,       32'hC0DE0080, 32'h84,       1, 12, 3, 2, 0));
      vq.push_back(mk(1, 0, 1, 32'h200,      1, 32'h83,       32'h80,       32'h0,        32'h0,        0, 13, 3, 3, 1));
      vq.push_back(mk(1, 0, 1, 32'h100,      0, 0,            32'h100,      32'h0,        32'h0,        0, 14, 3, 4, 1));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h104,      32'hC0DE0100, 32'h104,      1, 15, 3, 4, 1));
      vq.push_back(mk(1, 0, 0, 0,            1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 16, 3, 5, 1));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h0,        32'hC0DEFFFC, 32'h0,        1, 17, 3, 5, 1));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h4,        32'hC0DE0000, 32'h4,        1, 18, 3, 5, 1));
      vq.push_back(mk(0, 1, 1, 32'h300,      0, 0,            32'h4,        32'hC0DE0000, 32'h4,        1, 18, 3, 5, 1));
      vq.push_back(mk(0, 0, 0, 0,            1, 32'h400,      32'h4,        32'hC0DE0000, 32'h4,        1, 18, 3, 5, 1));
      vq.push_back(mk(0, 1, 0, 0,            0, 0,            32'h4,        32'hC0DE0000, 32'h4,        1, 18, 3, 5, 1));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h4,        32'hC0DE0000, 32'h4,        1, 18, 3, 5, 1));
      vq.push_back(mk(1, 0, 0, 0,            0, 0,            32'h8,        32'hC0DE0004, 32'h8,        1, 19, 3, 5, 1));

      repeat (2) @(negedge clk);
      rz = '{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, cyc: 32'h0, st: 32'h0, fl: 32'h0, mis: 1'b0};
      chk_all("reset", rz);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vq.size(); i++)
         step(vq[i], $sformatf("vec%0d", i));

      // Narrow counters: cycle count 19 saturates at 7, the others fit.
      chk("sat cyc",   {29'd0, s_cyc}, 32'd7);
      chk("sat stall", {29'd0, s_st},  32'd3);
      chk("sat flush", {29'd0, s_fl},  32'd5);
      chk("sat pc",    s_pc,           32'h8);

      // start dropped for three edges with other requests active: everything frozen.
      for (int i = 0; i < 3; i++)
         step(mk(0, i[0], 1, 32'h500, i[1], 32'h600, 32'h8, 32'hC0DE0004, 32'h8, 1, 19, 3, 5, 1),
              $sformatf("drop%0d", i));

      // Asynchronous reset between edges: must take effect without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", rz);
      chk("async_rst sat cyc", {29'd0, s_cyc}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(mk(1, 0, 0, 0, 0, 0, 32'h0, 32'h0,        32'h0, 0, 0, 0, 0, 0), "rerun0");
      step(mk(1, 0, 0, 0, 0, 0, 32'h4, 32'hC0DE0000, 32'h4, 1, 1, 0, 0, 0), "rerun1");

      chk("scoreboard empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
